// File: rtl/home_ctrl_fsm_param_if.sv
// Sensor/temperature request bus and actuator/display result bus of the home controller.
// master drives requests and observes the panel; slave is the controller itself.
interface home_ctrl_fsm_param_if #(
  parameter int unsigned N_SENS  = 4,
  parameter int unsigned TEMP_W  = 6,
  parameter int unsigned STATE_W = $clog2(N_SENS + 3)
);
  logic [N_SENS-1:0]  sensors;
  logic [TEMP_W-1:0]  temp;
  logic               ack;
  logic [N_SENS+1:0]  output_signals;
  logic [STATE_W-1:0] display;

  modport master (
    output sensors,
    output temp,
    output ack,
    input  output_signals,
    input  display
  );

  modport slave (
    input  sensors,
    input  temp,
    input  ack,
    output output_signals,
    output display
  );
endinterface

// File: rtl/home_ctrl_fsm_param.sv
// Priority-ranked home controller: sensor channels, heater/cooler with hysteresis,
// minimum-dwell timer and a channel-0 fire alarm that latches until acknowledged.
module home_ctrl_fsm_param #(
  parameter int unsigned N_SENS  = 4,
  parameter int unsigned TEMP_W  = 6,
  parameter int unsigned T_LOW   = 15,
  parameter int unsigned T_HIGH  = 35,
  parameter int unsigned HYST    = 2,
  parameter int unsigned DWELL   = 8,
  parameter int unsigned STATE_W = $clog2(N_SENS + 3)
) (
  input logic                    clk,
  input logic                    rst,
  home_ctrl_fsm_param_if.slave   bus
);

  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned TW1   = TEMP_W + 1;

  localparam logic [STATE_W-1:0] CODE_IDLE = '0;
  localparam logic [STATE_W-1:0] CODE_FIRE = STATE_W'(1);
  localparam logic [STATE_W-1:0] CODE_HEAT = STATE_W'(N_SENS + 1);
  localparam logic [STATE_W-1:0] CODE_COOL = STATE_W'(N_SENS + 2);
  localparam logic [CNT_W-1:0]   DWELL_MAX = CNT_W'(DWELL - 1);

  // Thresholds carry one extra bit so the +/-HYST variants cannot wrap.
  localparam logic [TW1-1:0] HEAT_LIM     = TW1'(T_LOW);
  localparam logic [TW1-1:0] HEAT_LIM_HYS = TW1'(T_LOW + HYST);
  localparam logic [TW1-1:0] COOL_LIM     = TW1'(T_HIGH);
  localparam logic [TW1-1:0] COOL_LIM_HYS = TW1'(T_HIGH - HYST);

  typedef enum logic [1:0] {StIdle, StSens, StHeat, StCool} kind_e;

  logic [STATE_W-1:0] display_q, display_d;
  logic [N_SENS+1:0]  out_q, out_d;
  logic [CNT_W-1:0]   dwell_q, dwell_d;

  kind_e              cur_kind;
  logic [STATE_W-1:0] tgt;
  logic [TW1-1:0]     temp_ext;
  logic [TW1-1:0]     heat_lim;
  logic [TW1-1:0]     cool_lim;
  logic               heat_req;
  logic               cool_req;
  logic               expired;
  logic               tgt_above;
  logic               move_ok;
  logic               fire_release;

  always_comb begin
    cur_kind     = StSens;
    tgt          = CODE_IDLE;
    temp_ext     = {1'b0, bus.temp};
    heat_lim     = HEAT_LIM;
    cool_lim     = COOL_LIM;
    heat_req     = 1'b0;
    cool_req     = 1'b0;
    expired      = (dwell_q == DWELL_MAX);
    tgt_above    = 1'b0;
    move_ok      = 1'b0;
    fire_release = 1'b0;
    display_d    = display_q;
    out_d        = '0;
    dwell_d      = dwell_q;

    if (display_q == CODE_IDLE) begin
      cur_kind = StIdle;
    end else if (display_q == CODE_HEAT) begin
      cur_kind = StHeat;
    end else if (display_q == CODE_COOL) begin
      cur_kind = StCool;
    end

    if (cur_kind == StHeat) heat_lim = HEAT_LIM_HYS;
    if (cur_kind == StCool) cool_lim = COOL_LIM_HYS;
    heat_req = (temp_ext < heat_lim);
    cool_req = (temp_ext > cool_lim);

    if (heat_req) begin
      tgt = CODE_HEAT;
    end else if (cool_req) begin
      tgt = CODE_COOL;
    end
    // Descending scan so the lowest active channel is assigned last and wins.
    for (int i = N_SENS - 1; i >= 0; i--) begin
      if (bus.sensors[i]) tgt = STATE_W'(i + 1);
    end

    // Rank key {is_idle, code}: smaller key means higher priority, IDLE lowest.
    tgt_above    = {tgt == CODE_IDLE, tgt} < {display_q == CODE_IDLE, display_q};
    move_ok      = tgt_above || ((tgt != display_q) && expired);
    fire_release = bus.ack && !bus.sensors[0] && expired;

    unique case (cur_kind)
      StIdle: display_d = tgt;
      StSens: begin
        if (display_q == CODE_FIRE) begin
          if (fire_release) display_d = tgt;
        end else if (move_ok) begin
          display_d = tgt;
        end
      end
      StHeat, StCool: begin
        if (move_ok) display_d = tgt;
      end
      default: display_d = display_q;
    endcase

    for (int i = 0; i < N_SENS + 2; i++) begin
      out_d[i] = (display_d == STATE_W'(i + 1));
    end

    if (display_d != display_q) begin
      dwell_d = '0;
    end else if (!expired) begin
      dwell_d = dwell_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      display_q <= CODE_IDLE;
      out_q     <= '0;
      dwell_q   <= '0;
    end else begin
      display_q <= display_d;
      out_q     <= out_d;
      dwell_q   <= dwell_d;
    end
  end

  assign bus.display        = display_q;
  assign bus.output_signals = out_q;

endmodule

// File: tb/tb_home_ctrl_fsm_param.sv
// Bench for home_ctrl_fsm_param: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a rank/age model of the controller.
module tb_home_ctrl_fsm_param;

  localparam int unsigned N_SENS  = 4;
  localparam int unsigned TEMP_W  = 6;
  localparam int unsigned T_LOW   = 15;
  localparam int unsigned T_HIGH  = 35;
  localparam int unsigned HYST    = 2;
  localparam int unsigned DWELL   = 8;
  localparam int unsigned STATE_W = $clog2(N_SENS + 3);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  home_ctrl_fsm_param_if #(
    .N_SENS (N_SENS),
    .TEMP_W (TEMP_W),
    .STATE_W(STATE_W)
  ) bus ();

  home_ctrl_fsm_param #(
    .N_SENS (N_SENS),
    .TEMP_W (TEMP_W),
    .T_LOW  (T_LOW),
    .T_HIGH (T_HIGH),
    .HYST   (HYST),
    .DWELL  (DWELL),
    .STATE_W(STATE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: current state code and number of edges spent in it since entry.
  int m_state = 0;
  int m_age   = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    tests_run++;
    if (act !== 32'(exp)) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rank(input int code);
    return (code == 0) ? N_SENS + 3 : code;
  endfunction

  function automatic int model_target(input int cur, input logic [N_SENS-1:0] s, input int t);
    int lo;
    int hi;
    for (int i = 0; i < N_SENS; i++) if (s[i]) return i + 1;
    lo = (cur == N_SENS + 1) ? T_LOW + HYST : T_LOW;
    hi = (cur == N_SENS + 2) ? T_HIGH - HYST : T_HIGH;
    if (t < lo) return N_SENS + 1;
    if (t > hi) return N_SENS + 2;
    return 0;
  endfunction

  always @(posedge clk) begin : compare
    int t;
    int nxt;
    bit expired;
    if (!rst) begin
      m_state = 0;
      m_age   = 0;
    end else begin
      t       = model_target(m_state, bus.sensors, int'(bus.temp));
      expired = (m_age >= DWELL - 1);
      if (m_state == 0) nxt = t;
      else if (m_state == 1) nxt = (bus.ack && !bus.sensors[0] && expired) ? t : 1;
      else if (rank(t) < rank(m_state)) nxt = t;
      else if (t == m_state) nxt = m_state;
      else nxt = expired ? t : m_state;
      m_age   = (nxt == m_state) ? m_age + 1 : 0;
      m_state = nxt;
    end
    #1;
    check("model_display", 32'(bus.display), m_state);
    check("model_onehot", 32'(bus.output_signals), (m_state == 0) ? 0 : (1 << (m_state - 1)));
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string name, input int exp_disp, input int exp_out);
    check({name, "_display"}, 32'(bus.display), exp_disp);
    check({name, "_outputs"}, 32'(bus.output_signals), exp_out);
  endtask

  initial begin
    bus.sensors = '0;
    bus.temp    = 6'd25;
    bus.ack     = 1'b0;

    // Reset with arbitrary inputs.
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.sensors = N_SENS'($urandom);
      bus.temp    = TEMP_W'($urandom);
      step();
    end
    lit("reset", 0, 0);
    rst = 1'b1; bus.sensors = '0; bus.temp = 6'd25;
    step();
    lit("reset_release", 0, 0);

    // Dwell hold after a one-cycle sensor pulse.
    bus.sensors = 4'b0100; step();
    lit("dwell_enter", 3, 6'b000100);
    bus.sensors = '0; step(7);
    lit("dwell_hold", 3, 6'b000100);
    step();
    lit("dwell_leave", 0, 0);

    // Pre-emption at count 2 restarts the dwell.
    bus.sensors = 4'b0100; step(3);
    bus.sensors = 4'b0110; step();
    lit("preempt", 2, 6'b000010);
    bus.sensors = '0; step(7);
    lit("preempt_hold", 2, 6'b000010);
    step();
    lit("preempt_leave", 0, 0);

    // Fire latch and acknowledge.
    bus.sensors = 4'b0001; step();
    lit("fire_enter", 1, 6'b000001);
    bus.sensors = '0; bus.ack = 1'b1; step();
    lit("fire_early_ack", 1, 6'b000001);
    bus.ack = 1'b0; step(9);
    lit("fire_latched", 1, 6'b000001);
    bus.sensors = 4'b0001; bus.ack = 1'b1; step();
    lit("fire_ack_active", 1, 6'b000001);
    bus.sensors = '0; step();
    lit("fire_cleared", 0, 0);
    bus.ack = 1'b0;

    // Heater/cooler hysteresis and strict thresholds.
    bus.temp = 6'd14; step();
    lit("heat_enter", 5, 6'b010000);
    step(8);
    bus.temp = 6'd16; step();
    lit("heat_hyst", 5, 6'b010000);
    bus.temp = 6'd17; step();
    lit("heat_leave", 0, 0);
    bus.temp = 6'd36; step();
    lit("cool_enter", 6, 6'b100000);
    bus.temp = 6'd34; step();
    lit("cool_hyst", 6, 6'b100000);
    step(8);
    lit("cool_hyst_late", 6, 6'b100000);
    bus.temp = 6'd33; step();
    lit("cool_leave", 0, 0);
    bus.temp = 6'd15; step();
    lit("edge_low", 0, 0);
    bus.temp = 6'd35; step();
    lit("edge_high", 0, 0);
    bus.temp = 6'd25;

    // Reset in the middle of a fire alarm.
    bus.sensors = 4'b0001; step();
    lit("fire_again", 1, 6'b000001);
    rst = 1'b0; step();
    lit("mid_reset", 0, 0);
    rst = 1'b1; step();
    lit("post_reset_fire", 1, 6'b000001);
    bus.sensors = '0; bus.ack = 1'b1; step(7);
    lit("post_reset_hold", 1, 6'b000001);
    step();
    lit("post_reset_clear", 0, 0);
    bus.ack = 1'b0;

    // Randomized traffic concentrated around the thresholds.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      for (int b = 0; b < N_SENS; b++) bus.sensors[b] = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) bus.temp = TEMP_W'($urandom_range(0, 63));
      else bus.temp = TEMP_W'($urandom_range(11, 39));
      bus.ack = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/home_ctrl_fsm_param.md
Name: home_ctrl_fsm_param

Overview:
Parametrised successor to the home-automation controller FSM. Monitors N_SENS binary sensor channels and a TEMP_W-bit temperature input. Selects one active state by fixed priority, with a minimum-dwell timer, temperature hysteresis and a latched channel-0 (fire) alarm that needs an acknowledge to clear. Drives registered one-hot actuator outputs and a binary state code for the panel display.

Parameters:
N_SENS, 4, number of sensor channels; channel 0 has highest priority.
TEMP_W, 6, temperature input width (unsigned).
T_LOW, 15, heater requested when temp < T_LOW.
T_HIGH, 35, cooler requested when temp > T_HIGH.
HYST, 2, hysteresis band applied while already heating or cooling.
DWELL, 8, minimum cycles spent in any non-IDLE state before a lower-priority move (DWELL >= 1).
STATE_W, $clog2(N_SENS+3), width of the state code.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  synchronous, active-low reset.
sensors  in  N_SENS  sensor request lines, level-sensitive.
temp  in  TEMP_W  current temperature, unsigned.
ack  in  1  operator acknowledge for the channel-0 alarm.
output_signals  out  N_SENS+2  registered one-hot actuators: bit i = SENS_i, bit N_SENS = heater, bit N_SENS+1 = cooler.
display  out  STATE_W  registered state code.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-low: rst=0 at a rising edge forces the reset state; there is no asynchronous path.
- Reset state: display=0 (IDLE), output_signals=0, dwell counter=0. Reset has priority over every other input, including mid-alarm.
- State codes: IDLE=0; SENS_i=1+i; HEAT=N_SENS+1; COOL=N_SENS+2.
- Rank order, highest first: SENS_0 .. SENS_{N_SENS-1}, HEAT, COOL, IDLE.
- Requests are evaluated combinationally each cycle:
  - SENS_i requested when sensors[i]=1.
  - HEAT requested when temp < T_LOW. While the current state is HEAT, the threshold becomes temp < T_LOW+HYST.
  - COOL requested when temp > T_HIGH. While the current state is COOL, the threshold becomes temp > T_HIGH-HYST.
  - Comparisons are strict. Widen by one bit for the +/-HYST arithmetic. Design requires T_LOW+HYST <= T_HIGH-HYST, so HEAT and COOL never both request.
- Target = highest-ranked active request; IDLE if none.
- Transition rules, evaluated in order:
  1. Current state SENS_0: stay unless ack=1 AND sensors[0]=0 AND dwell expired. Then move to target, re-evaluated with sensors[0]=0. ack in any other state is ignored.
  2. Target ranks above current state: move on the next edge regardless of dwell (pre-emption).
  3. Target equals current state: stay.
  4. Target ranks below current state: move only when dwell has expired; otherwise stay.
  5. From IDLE: move to target immediately. IDLE has no dwell.
- Dwell counter:
  - Width $clog2(DWELL).
  - Cleared to 0 on every edge where display changes; otherwise increments, saturating at DWELL-1.
  - Expired when count == DWELL-1. Any non-IDLE state is therefore held for at least DWELL cycles unless pre-empted.
- Latency: inputs sampled at edge k appear on display/output_signals after edge k. One-cycle registered decision, no combinational input-to-output path.
- output_signals is the one-hot decode of the next state, registered in the same edge as display, so the two are always consistent. IDLE gives all zeros. Never more than one bit set.
- Simultaneous events: several sensors active -> lowest index wins. Sensor and temperature requests together -> sensor wins. rst=0 together with anything -> reset.

Test Plan (defaults: N_SENS=4, TEMP_W=6, T_LOW=15, T_HIGH=35, HYST=2, DWELL=8; temp=25 unless stated):
1. Reset: rst=0 for 2 cycles, random sensors/temp -> display=0, output_signals=6'b000000; first edge with rst=1 and sensors=0 keeps IDLE.
2. Dwell: sensors=4'b0100 for one cycle at edge k -> display=3 and output_signals=6'b000100 from edge k+1, held through edge k+8, display=0 after edge k+9.
3. Pre-emption: in SENS_2 with count=2, raise sensors[1] -> next edge display=2, output_signals=6'b000010, counter=0.
4. Fire latch: sensors[0] one-cycle pulse -> display=1 persists past 8 cycles; ack=1 while sensors[0]=1 -> still 1; ack=1 with sensors[0]=0 after dwell -> display=0 next edge.
5. Hysteresis:
   - temp=14 -> display=5, output_signals=6'b010000; after dwell temp=16 -> stays 5; temp=17 -> display=0.
   - temp=36 -> display=6, output_signals=6'b100000; temp=34 stays 6; temp=33 -> display=0.
   - temp=15 or 35 from IDLE -> stays IDLE.
6. Reset mid-operation: in SENS_0 with ack=0, drive rst=0 -> next edge display=0, output_signals=0, counter=0; release with sensors[0]=1 -> display=1 next edge.
